// File: rtl/lm75_poll_sequencer_if.sv
// lm75_poll_sequencer_if: byte-level I2C master command/response port.
interface lm75_poll_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_nack;
  modport master (output cmd_valid, cmd, cmd_data, input cmd_ready, rsp_valid, rsp_data, rsp_nack);
  modport slave (input cmd_valid, cmd, cmd_data, output cmd_ready, rsp_valid, rsp_data, rsp_nack);
endinterface

// File: rtl/lm75_poll_sequencer.sv
// lm75_poll_sequencer: periodic LM75 temperature read with NACK retry and C/F conversion.
module lm75_poll_sequencer #(
  parameter int         POLL_CYCLES = 6_250_000,
  parameter logic [6:0] DEV_ADDR    = 7'h48,
  parameter int         MAX_RETRY   = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  lm75_poll_sequencer_if.master       bus,
  output logic [7:0]                  temp_celsius,
  output logic [7:0]                  temp_fahrenheit,
  output logic                        temp_valid,
  output logic                        sensor_err,
  output logic                        busy
);
  typedef enum logic [3:0] {
    IDLE, START1, ADDR_W, PTR, START2, ADDR_R, RD_MSB, RD_LSB, STOP, UPDATE, ERR_STOP
  } state_t;
  localparam logic [31:0] RELOAD  = 32'(POLL_CYCLES - 1);
  localparam logic [7:0]  RETRIES = 8'(MAX_RETRY);
  state_t      state;
  logic        wait_rsp;
  logic [31:0] timer;
  logic [7:0]  fail_cnt, msb, c, f, ndata;
  logic [2:0]  ncmd;
  always_comb begin
    ncmd  = (state == START1 || state == START2) ? 3'd0 :
            (state == ADDR_W || state == PTR || state == ADDR_R) ? 3'd1 :
            (state == RD_MSB) ? 3'd2 : (state == RD_LSB) ? 3'd3 : 3'd4;
    ndata = (state == ADDR_W) ? {DEV_ADDR, 1'b0} : (state == ADDR_R) ? {DEV_ADDR, 1'b1} : 8'h00;
    c     = msb[7] ? 8'd0 : (msb > 8'd99) ? 8'd99 : msb;
    f     = 8'(({8'd0, c} * 16'd461) >> 8) + 8'd32;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      wait_rsp        <= 1'b0;
      timer           <= '0;
      fail_cnt        <= '0;
      msb             <= '0;
      bus.cmd_valid   <= 1'b0;
      bus.cmd         <= '0;
      bus.cmd_data    <= '0;
      temp_celsius    <= '0;
      temp_fahrenheit <= '0;
      temp_valid      <= 1'b0;
      sensor_err      <= 1'b0;
      busy            <= 1'b0;
    end else begin
      temp_valid <= 1'b0;
      busy       <= state != IDLE;
      if (timer != 0) timer <= timer - 32'd1;
      if (state == IDLE) begin
        if (timer == 0) begin
          state <= START1;
          timer <= RELOAD;
        end
      end else if (state == UPDATE) begin
        temp_celsius    <= c;
        temp_fahrenheit <= f;
        temp_valid      <= 1'b1;
        sensor_err      <= 1'b0;
        fail_cnt        <= '0;
        state           <= IDLE;
      end else if (!wait_rsp) begin
        if (!bus.cmd_valid) begin
          bus.cmd_valid <= 1'b1;
          bus.cmd       <= ncmd;
          bus.cmd_data  <= ndata;
        end else if (bus.cmd_ready) begin
          bus.cmd_valid <= 1'b0;
          wait_rsp      <= 1'b1;
        end
      end else if (bus.rsp_valid) begin
        wait_rsp <= 1'b0;
        if (state == ERR_STOP) begin
          // retries bypass the poll timer; giving up waits for the next interval
          if (fail_cnt < RETRIES) begin
            state <= START1;
            timer <= RELOAD;
          end else begin
            sensor_err <= 1'b1;
            fail_cnt   <= '0;
            state      <= IDLE;
          end
        end else if (ncmd == 3'd1 && bus.rsp_nack) begin
          state    <= ERR_STOP;
          fail_cnt <= fail_cnt + 8'd1;
        end else begin
          if (state == RD_MSB) msb <= bus.rsp_data;
          state <= state_t'(state + 4'd1);
        end
      end
    end
  end
endmodule

// File: tb/tb_lm75_poll_sequencer.sv
// tb_lm75_poll_sequencer: directed checks against an I2C master / LM75 response model.
module tb_lm75_poll_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  lm75_poll_sequencer_if bus ();
  logic [7:0] temp_celsius, temp_fahrenheit;
  logic       temp_valid, sensor_err, busy;
  lm75_poll_sequencer #(.POLL_CYCLES(1000), .DEV_ADDR(7'h48), .MAX_RETRY(3)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .temp_celsius(temp_celsius), .temp_fahrenheit(temp_fahrenheit),
    .temp_valid(temp_valid), .sensor_err(sensor_err), .busy(busy)
  );
  localparam logic [10:0] NOM [8] = '{11'h000, 11'h190, 11'h100, 11'h000, 11'h191, 11'h200, 11'h300, 11'h400};
  int checks = 0, errors = 0;
  logic [7:0] msb_val = 8'h00, lsb_val = 8'h00;
  int nack_addr = 0, nack_ptr = 0, bp = 0;
  int tv_cnt = 0, stab_viol = 0, cyc = 0;
  logic [10:0] log_q [$];
  int time_q [$];
  logic [10:0] exp_q [$];
  initial forever begin
    @(posedge clk);
    cyc++;
  end
  initial forever begin
    @(negedge clk);
    if (temp_valid) tv_cnt++;
  end
  // command acceptor: bp cycles of backpressure, response three cycles after the handshake
  initial begin
    int wcnt, rcnt;
    logic pend, nk;
    logic [10:0] held;
    logic [7:0] rd;
    wcnt = 0; rcnt = 0; pend = 0; nk = 0; held = '0; rd = '0;
    bus.cmd_ready = 0; bus.rsp_valid = 0; bus.rsp_data = 0; bus.rsp_nack = 0;
    forever begin
      @(negedge clk);
      bus.rsp_valid = 0; bus.rsp_nack = 0; bus.rsp_data = 0; bus.cmd_ready = 0;
      if (!rst) begin
        pend = 0;
        wcnt = 0;
      end else if (pend) begin
        if (rcnt == 0) begin
          bus.rsp_valid = 1; bus.rsp_data = rd; bus.rsp_nack = nk; pend = 0;
        end else rcnt--;
      end else if (bus.cmd_valid) begin
        if (wcnt == 0) held = {bus.cmd, bus.cmd_data};
        else if ({bus.cmd, bus.cmd_data} !== held) stab_viol++;
        if (wcnt < bp) wcnt++;
        else begin
          bus.cmd_ready = 1; wcnt = 0; pend = 1; rcnt = 2;
          log_q.push_back({bus.cmd, bus.cmd_data});
          time_q.push_back(cyc);
          rd = (bus.cmd == 3'd2) ? msb_val : (bus.cmd == 3'd3) ? lsb_val : 8'h00;
          nk = 0;
          if (bus.cmd == 3'd1 && bus.cmd_data == 8'h90 && nack_addr > 0) begin nk = 1; nack_addr--; end
          if (bus.cmd == 3'd1 && bus.cmd_data == 8'h00 && nack_ptr > 0) begin nk = 1; nack_ptr--; end
        end
      end
    end
  end
  task automatic do_poll(input string name);
    int n;
    n = 0;
    while (busy !== 1'b1 && n < 5000) begin @(negedge clk); n++; end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL %s_start: busy=%b required 1 within 5000 cycles", name, busy); end
    n = 0;
    while (busy !== 1'b0 && n < 5000) begin @(negedge clk); n++; end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL %s_done: busy=%b required 0 within 5000 cycles", name, busy); end
    repeat (2) @(negedge clk);
  endtask
  task automatic clear_obs();
    log_q.delete();
    time_q.delete();
    tv_cnt = 0;
  endtask
  task automatic test_reset();
    msb_val = 8'h19; lsb_val = 8'h80;
    clear_obs();
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.cmd_valid, bus.cmd, bus.cmd_data} !== 12'h0) begin
      errors++; $display("FAIL reset_cmd: valid/cmd/data=%h required 000", {bus.cmd_valid, bus.cmd, bus.cmd_data});
    end
    checks++;
    if ({temp_celsius, temp_fahrenheit, temp_valid, sensor_err, busy} !== 19'h0) begin
      errors++; $display("FAIL reset_out: C=%0d F=%0d tv=%b err=%b busy=%b required all 0", temp_celsius, temp_fahrenheit, temp_valid, sensor_err, busy);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.cmd_valid !== 1'b0) begin errors++; $display("FAIL release_c1: cmd_valid=%b required 0", bus.cmd_valid); end
    @(negedge clk);
    checks++;
    if ({bus.cmd_valid, bus.cmd} !== 4'b1000) begin errors++; $display("FAIL release_c2: valid=%b cmd=%0d required 1/0", bus.cmd_valid, bus.cmd); end
  endtask
  task automatic test_nominal();
    do_poll("nominal");
    checks++;
    if (log_q.size() != 8) begin errors++; $display("FAIL nominal_len: got %0d commands required 8", log_q.size()); end
    for (int i = 0; i < 8 && i < log_q.size(); i++) begin
      checks++;
      if (log_q[i] !== NOM[i]) begin errors++; $display("FAIL nominal_cmd%0d: got %h required %h", i, log_q[i], NOM[i]); end
    end
    checks++;
    if (temp_celsius !== 8'd25) begin errors++; $display("FAIL nominal_c: got %0d required 25", temp_celsius); end
    checks++;
    if (temp_fahrenheit !== 8'd77) begin errors++; $display("FAIL nominal_f: got %0d required 77", temp_fahrenheit); end
    checks++;
    if (tv_cnt != 1) begin errors++; $display("FAIL nominal_tv: got %0d pulses required 1", tv_cnt); end
    checks++;
    if (sensor_err !== 1'b0) begin errors++; $display("FAIL nominal_err: got %b required 0", sensor_err); end
  endtask
  task automatic test_clamp();
    logic [7:0] vin [5] = '{8'hF6, 8'h7D, 8'h80, 8'h63, 8'h64};
    logic [7:0] vc [5]  = '{8'd0, 8'd99, 8'd0, 8'd99, 8'd99};
    logic [7:0] vf [5]  = '{8'd32, 8'd210, 8'd32, 8'd210, 8'd210};
    for (int k = 0; k < 5; k++) begin
      msb_val = vin[k]; lsb_val = 8'h00;
      clear_obs();
      do_poll("clamp");
      checks++;
      if (temp_celsius !== vc[k]) begin errors++; $display("FAIL clamp_c[%h]: got %0d required %0d", vin[k], temp_celsius, vc[k]); end
      checks++;
      if (temp_fahrenheit !== vf[k]) begin errors++; $display("FAIL clamp_f[%h]: got %0d required %0d", vin[k], temp_fahrenheit, vf[k]); end
      checks++;
      if (tv_cnt != 1) begin errors++; $display("FAIL clamp_tv[%h]: got %0d required 1", vin[k], tv_cnt); end
    end
  endtask
  task automatic test_persistent_nack();
    nack_addr = 3;
    clear_obs();
    exp_q.delete();
    repeat (3) begin exp_q.push_back(11'h000); exp_q.push_back(11'h190); exp_q.push_back(11'h400); end
    do_poll("nack3");
    checks++;
    if (log_q.size() != 9) begin errors++; $display("FAIL nack3_len: got %0d commands required 9", log_q.size()); end
    for (int i = 0; i < 9 && i < log_q.size(); i++) begin
      checks++;
      if (log_q[i] !== exp_q[i]) begin errors++; $display("FAIL nack3_cmd%0d: got %h required %h", i, log_q[i], exp_q[i]); end
    end
    checks++;
    if (sensor_err !== 1'b1) begin errors++; $display("FAIL nack3_err: got %b required 1", sensor_err); end
    checks++;
    if ({temp_celsius, temp_fahrenheit} !== {8'd99, 8'd210}) begin errors++; $display("FAIL nack3_hold: C=%0d F=%0d required 99/210", temp_celsius, temp_fahrenheit); end
    checks++;
    if (tv_cnt != 0) begin errors++; $display("FAIL nack3_tv: got %0d required 0", tv_cnt); end
    msb_val = 8'h19;
    clear_obs();
    do_poll("recover");
    checks++;
    if (sensor_err !== 1'b0) begin errors++; $display("FAIL recover_err: got %b required 0", sensor_err); end
    checks++;
    if (temp_celsius !== 8'd25 || tv_cnt != 1) begin errors++; $display("FAIL recover_c: C=%0d tv=%0d required 25/1", temp_celsius, tv_cnt); end
  endtask
  task automatic test_single_nack();
    nack_ptr = 1; msb_val = 8'h1E;
    clear_obs();
    exp_q.delete();
    exp_q.push_back(11'h000); exp_q.push_back(11'h190); exp_q.push_back(11'h100); exp_q.push_back(11'h400);
    for (int i = 0; i < 8; i++) exp_q.push_back(NOM[i]);
    do_poll("nack1");
    checks++;
    if (log_q.size() != 12) begin errors++; $display("FAIL nack1_len: got %0d commands required 12", log_q.size()); end
    for (int i = 0; i < 12 && i < log_q.size(); i++) begin
      checks++;
      if (log_q[i] !== exp_q[i]) begin errors++; $display("FAIL nack1_cmd%0d: got %h required %h", i, log_q[i], exp_q[i]); end
    end
    checks++;
    if ({temp_celsius, temp_fahrenheit} !== {8'd30, 8'd86}) begin errors++; $display("FAIL nack1_temp: C=%0d F=%0d required 30/86", temp_celsius, temp_fahrenheit); end
    checks++;
    if (tv_cnt != 1) begin errors++; $display("FAIL nack1_tv: got %0d required 1", tv_cnt); end
    checks++;
    if (sensor_err !== 1'b0) begin errors++; $display("FAIL nack1_err: got %b required 0", sensor_err); end
  endtask
  task automatic test_back_to_back();
    bp = 10; msb_val = 8'h19; stab_viol = 0;
    clear_obs();
    do_poll("bp_a");
    do_poll("bp_b");
    bp = 0;
    checks++;
    if (stab_viol != 0) begin errors++; $display("FAIL bp_stable: got %0d changes required 0", stab_viol); end
    checks++;
    if (log_q.size() != 16) begin errors++; $display("FAIL bp_len: got %0d commands required 16", log_q.size()); end
    else begin
      checks++;
      if (time_q[8] - time_q[0] != 1000) begin errors++; $display("FAIL bp_interval: got %0d cycles required 1000", time_q[8] - time_q[0]); end
      checks++;
      if (log_q[8] !== 11'h000 || log_q[9] !== 11'h190) begin errors++; $display("FAIL bp_second: got %h %h required 000 190", log_q[8], log_q[9]); end
    end
    checks++;
    if (temp_celsius !== 8'd25 || tv_cnt != 2) begin errors++; $display("FAIL bp_temp: C=%0d tv=%0d required 25/2", temp_celsius, tv_cnt); end
  endtask
  task automatic test_reset_mid();
    int n;
    msb_val = 8'h14;
    clear_obs();
    n = 0;
    while (!(log_q.size() > 0 && log_q[log_q.size()-1] == 11'h200) && n < 3000) begin @(negedge clk); n++; end
    checks++;
    if (n >= 3000) begin errors++; $display("FAIL rmid_reach: RD_MSB handshake not seen in %0d cycles required <3000", n); end
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({bus.cmd_valid, bus.cmd, bus.cmd_data, temp_celsius, temp_fahrenheit, temp_valid, sensor_err, busy} !== 31'h0) begin
      errors++; $display("FAIL rmid_async: valid=%b cmd=%0d data=%h C=%0d F=%0d tv=%b err=%b busy=%b required all 0",
        bus.cmd_valid, bus.cmd, bus.cmd_data, temp_celsius, temp_fahrenheit, temp_valid, sensor_err, busy);
    end
    clear_obs();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.cmd_valid !== 1'b0) begin errors++; $display("FAIL rmid_c1: cmd_valid=%b required 0", bus.cmd_valid); end
    @(negedge clk);
    checks++;
    if ({bus.cmd_valid, bus.cmd} !== 4'b1000) begin errors++; $display("FAIL rmid_c2: valid=%b cmd=%0d required 1/0", bus.cmd_valid, bus.cmd); end
    do_poll("rmid");
    checks++;
    if (log_q.size() != 8) begin errors++; $display("FAIL rmid_len: got %0d commands required 8", log_q.size()); end
    for (int i = 0; i < 8 && i < log_q.size(); i++) begin
      checks++;
      if (log_q[i] !== NOM[i]) begin errors++; $display("FAIL rmid_cmd%0d: got %h required %h", i, log_q[i], NOM[i]); end
    end
    checks++;
    if ({temp_celsius, temp_fahrenheit} !== {8'd20, 8'd68} || tv_cnt != 1) begin
      errors++; $display("FAIL rmid_temp: C=%0d F=%0d tv=%0d required 20/68/1", temp_celsius, temp_fahrenheit, tv_cnt);
    end
  endtask
  initial begin
    test_reset();
    test_nominal();
    test_clamp();
    test_persistent_nack();
    test_single_nack();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
